prog_stream_loader: RTL and testbench

- Boot-time program loader that drives the core's programming interface (en, prog, addr, instr) from a byte stream, e.g. a UART receiver or debug FIFO.
- Consumes a little-endian 32-bit word count, then that many little-endian instruction words.
- Writes each word into instruction memory at consecutive word addresses, then drops prog and raises en to release the core.
- Sits between the byte source and single_cycle_r32i; it replaces the directed-instruction driver used in simulation.

---
 rtl/prog_stream_loader_if.sv | 32 +++
 rtl/prog_stream_loader.sv | 182 ++++++++++++++++++
 tb/tb_prog_stream_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_stream_loader_if.sv
// rtl/prog_stream_loader_if.sv - byte stream, core programming and status bundle for prog_stream_loader
//
// Signals:
//   s_data/s_valid/s_ready : byte stream from the source (UART receiver, debug FIFO)
//   prog/en/addr/instr     : core programming interface toward single_cycle_r32i
//   busy/done/err/word_cnt : loader status
// Modports:
//   master : the environment side (drives the byte stream, observes everything else)
//   slave  : the loader side
interface prog_stream_loader_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        prog;
    logic        en;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_cnt;

    modport master (
        output s_data, s_valid,
        input  s_ready, prog, en, addr, instr, busy, done, err, word_cnt
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, prog, en, addr, instr, busy, done, err, word_cnt
    );
endinterface

// File: rtl/prog_stream_loader.sv
// rtl/prog_stream_loader.sv - boot-time loader writing a little-endian byte stream into instruction memory
//
// Ports:
//   clk  : system clock, all logic on posedge
//   rst  : synchronous active-high reset, priority over everything
//   bus  : prog_stream_loader_if.slave
//          s_data/s_valid in, s_ready out      - byte stream, transfer on s_valid && s_ready
//          prog/en/addr/instr out              - core programming interface
//          busy/done/err/word_cnt out          - status
// Stream format: 32-bit word count (LE), then that many 32-bit instruction words (LE).
// Every output is registered; next values are computed from the next state.
module prog_stream_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    prog_stream_loader_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_LEN,
        ST_CHECK,
        ST_DATA,
        ST_FLUSH,
        ST_RUN,
        ST_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] len_q, len_d;
    // Only the three lower bytes need storing; the fourth arrives on the completing edge.
    logic [23:0] word_q, word_d;

    logic        s_ready_q, s_ready_d;
    logic        prog_q, prog_d;
    logic        en_q, en_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] word_cnt_q, word_cnt_d;

    logic        xfer;
    logic [15:0] word_cnt_inc;

    assign xfer         = bus.s_valid && s_ready_q;
    assign word_cnt_inc = word_cnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        len_d      = len_q;
        word_d     = word_q;
        prog_d     = prog_q;
        en_d       = en_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        word_cnt_d = word_cnt_q;
        s_ready_d  = 1'b0;

        case (state_q)
            ST_LEN: begin
                if (xfer) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: len_d[7:0]   = bus.s_data;
                        2'd1: len_d[15:8]  = bus.s_data;
                        2'd2: len_d[23:16] = bus.s_data;
                        default: begin
                            len_d[31:24] = bus.s_data;
                            state_d      = ST_CHECK;
                        end
                    endcase
                end
            end

            ST_CHECK: begin
                if (len_q == 32'd0 || len_q > 32'(MAX_WORDS)) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (xfer) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = bus.s_data;
                        2'd1: word_d[15:8]  = bus.s_data;
                        2'd2: word_d[23:16] = bus.s_data;
                        default: begin
                            // addr and instr move together so the core never sees a mixed pair.
                            instr_d    = {bus.s_data, word_q};
                            prog_d     = 1'b1;
                            addr_d     = (word_cnt_q == 16'd0) ? BASE_ADDR : addr_q + 32'd4;
                            word_cnt_d = word_cnt_inc;
                            if ({16'd0, word_cnt_inc} == len_q) begin
                                state_d = ST_FLUSH;
                            end
                        end
                    endcase
                end
            end

            // One extra cycle with prog high so the final word gets a full write edge.
            ST_FLUSH: state_d = ST_RUN;

            ST_RUN:   state_d = ST_RUN;

            ST_ERR:   state_d = ST_ERR;

            default:  state_d = ST_ERR;
        endcase

        // Outputs follow the state being entered, so they line up with it on the same edge.
        s_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA);

        if (state_d == ST_RUN) begin
            prog_d = 1'b0;
            en_d   = 1'b1;
            done_d = 1'b1;
            busy_d = 1'b0;
        end

        if (state_d == ST_ERR) begin
            prog_d = 1'b0;
            en_d   = 1'b0;
            err_d  = 1'b1;
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LEN;
            byte_idx_q <= 2'd0;
            len_q      <= 32'd0;
            word_q     <= 24'd0;
            s_ready_q  <= 1'b0;
            prog_q     <= 1'b0;
            en_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            instr_q    <= 32'd0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            word_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            len_q      <= len_d;
            word_q     <= word_d;
            s_ready_q  <= s_ready_d;
            prog_q     <= prog_d;
            en_q       <= en_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.prog     = prog_q;
    assign bus.en       = en_q;
    assign bus.addr     = addr_q;
    assign bus.instr    = instr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.word_cnt = word_cnt_q;

endmodule

// File: tb/tb_prog_stream_loader.sv
// tb/tb_prog_stream_loader.sv - directed self-checking bench for prog_stream_loader
module tb_prog_stream_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    prog_stream_loader_if bus0 ();
    prog_stream_loader_if bus1 ();

    prog_stream_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    prog_stream_loader #(.BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(1024)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // Core memory models plus a log of distinct (addr, instr) pairs seen while prog is high.
    logic [31:0] mem0 [logic [31:0]];
    logic [31:0] mem1 [logic [31:0]];
    logic [31:0] wlog_addr [$];
    logic [31:0] wlog_instr [$];
    bit          prog_seen0;

    always @(negedge clk) begin
        if (bus0.prog === 1'b1) begin
            prog_seen0 = 1'b1;
            mem0[bus0.addr] = bus0.instr;
            if (wlog_addr.size() == 0 ||
                wlog_addr[$] !== bus0.addr || wlog_instr[$] !== bus0.instr) begin
                wlog_addr.push_back(bus0.addr);
                wlog_instr.push_back(bus0.instr);
            end
        end
        if (bus1.prog === 1'b1) mem1[bus1.addr] = bus1.instr;
    end

    function automatic logic [31:0] rd0(input logic [31:0] a);
        if (mem0.exists(a)) return mem0[a];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] rd1(input logic [31:0] a);
        if (mem1.exists(a)) return mem1[a];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_logs();
        mem0.delete();
        mem1.delete();
        wlog_addr.delete();
        wlog_instr.delete();
        prog_seen0 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus0.s_valid = 1'b0;
        bus1.s_valid = 1'b0;
        tick(1);
        rst = 1'b0;
        clear_logs();
    endtask

    // Holds s_valid high with byte b until it is accepted; leaves s_valid high on return.
    task automatic send_byte(input int sel, input logic [7:0] b);
        logic rdy;
        int   n;
        n = 0;
        if (sel == 0) begin bus0.s_data = b; bus0.s_valid = 1'b1; end
        else          begin bus1.s_data = b; bus1.s_valid = 1'b1; end
        do begin
            rdy = (sel == 0) ? bus0.s_ready : bus1.s_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 40);
        if (!rdy) begin
            tests++; failed++;
            $display("FAIL send_byte_timeout dut=%0d byte=%h never accepted in 40 cycles", sel, b);
        end
    endtask

    task automatic send_bytes(input int sel, input logic [7:0] bs [$]);
        foreach (bs[i]) send_byte(sel, bs[i]);
        if (sel == 0) bus0.s_valid = 1'b0; else bus1.s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.s_valid = 1'b0;
        bus1.s_valid = 1'b0;
        tick(2);
        tests++; if (bus0.s_ready !== 1'b0) begin failed++; $display("FAIL rst_s_ready got %b exp 0", bus0.s_ready); end
        tests++; if (bus0.prog !== 1'b0) begin failed++; $display("FAIL rst_prog got %b exp 0", bus0.prog); end
        tests++; if (bus0.en !== 1'b0) begin failed++; $display("FAIL rst_en got %b exp 0", bus0.en); end
        tests++; if (bus0.addr !== 32'h0) begin failed++; $display("FAIL rst_addr got %h exp 0", bus0.addr); end
        tests++; if (bus1.addr !== 32'hFFFF_FFFC) begin failed++; $display("FAIL rst_addr_base got %h exp fffffffc", bus1.addr); end
        tests++; if (bus0.instr !== 32'h0) begin failed++; $display("FAIL rst_instr got %h exp 0", bus0.instr); end
        tests++; if (bus0.busy !== 1'b1 || bus0.done !== 1'b0 || bus0.err !== 1'b0) begin
            failed++; $display("FAIL rst_status got busy=%b done=%b err=%b exp 1/0/0", bus0.busy, bus0.done, bus0.err); end
        tests++; if (bus0.word_cnt !== 16'd0) begin failed++; $display("FAIL rst_word_cnt got %0d exp 0", bus0.word_cnt); end
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_basic_load();
        logic [7:0] lenb [$] = '{8'h02, 8'h00, 8'h00, 8'h00};
        logic [7:0] w0 [$]   = '{8'h13, 8'h05, 8'h10, 8'h00};
        logic [7:0] w1 [$]   = '{8'hB7, 8'hF2, 8'hFF, 8'hFF};
        do_reset();
        foreach (lenb[i]) send_byte(0, lenb[i]);
        // In CHECK with s_valid still high: nothing may be accepted.
        tests++; if (bus0.s_ready !== 1'b0) begin failed++; $display("FAIL basic_check_s_ready got %b exp 0", bus0.s_ready); end
        tick(1);
        tests++; if (bus0.s_ready !== 1'b1) begin failed++; $display("FAIL basic_data_s_ready got %b exp 1", bus0.s_ready); end
        tests++; if (bus0.prog !== 1'b0) begin failed++; $display("FAIL basic_prog_before_word got %b exp 0", bus0.prog); end
        foreach (w0[i]) send_byte(0, w0[i]);
        tests++; if (bus0.prog !== 1'b1 || bus0.addr !== 32'h0 || bus0.instr !== 32'h0010_0513) begin
            failed++; $display("FAIL basic_word0 got prog=%b addr=%h instr=%h exp 1/00000000/00100513", bus0.prog, bus0.addr, bus0.instr); end
        tests++; if (bus0.word_cnt !== 16'd1) begin failed++; $display("FAIL basic_cnt1 got %0d exp 1", bus0.word_cnt); end
        foreach (w1[i]) send_byte(0, w1[i]);
        // Now in FLUSH.
        tests++; if (bus0.prog !== 1'b1 || bus0.addr !== 32'h4 || bus0.instr !== 32'hFFFF_F2B7 || bus0.en !== 1'b0) begin
            failed++; $display("FAIL basic_flush got prog=%b addr=%h instr=%h en=%b exp 1/00000004/fffff2b7/0",
                               bus0.prog, bus0.addr, bus0.instr, bus0.en); end
        tests++; if (bus0.s_ready !== 1'b0) begin failed++; $display("FAIL basic_flush_s_ready got %b exp 0", bus0.s_ready); end
        tick(1);
        tests++; if (bus0.prog !== 1'b0 || bus0.en !== 1'b1 || bus0.done !== 1'b1 || bus0.busy !== 1'b0) begin
            failed++; $display("FAIL basic_run got prog=%b en=%b done=%b busy=%b exp 0/1/1/0", bus0.prog, bus0.en, bus0.done, bus0.busy); end
        tests++; if (bus0.word_cnt !== 16'd2) begin failed++; $display("FAIL basic_cnt2 got %0d exp 2", bus0.word_cnt); end
        tests++; if (rd0(32'h0) !== 32'h0010_0513 || rd0(32'h4) !== 32'hFFFF_F2B7) begin
            failed++; $display("FAIL basic_mem got [0]=%h [4]=%h exp 00100513/fffff2b7", rd0(32'h0), rd0(32'h4)); end
        bus0.s_valid = 1'b0;
    endtask

    // Bytes offered in a terminal state must be refused and change nothing.
    task automatic test_ignore(input string tag, input logic exp_en, input logic exp_err,
                               input logic [15:0] exp_cnt, input logic [31:0] exp_addr,
                               input logic [31:0] exp_instr);
        int bad_ready;
        bad_ready = 0;
        bus0.s_data  = 8'hA5;
        bus0.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus0.s_ready !== 1'b0) bad_ready++;
            tick(1);
        end
        bus0.s_valid = 1'b0;
        tests++; if (bad_ready != 0) begin failed++; $display("FAIL ignore_%s_s_ready got %0d ready cycles exp 0", tag, bad_ready); end
        tests++; if (bus0.en !== exp_en || bus0.err !== exp_err || bus0.prog !== 1'b0) begin
            failed++; $display("FAIL ignore_%s_flags got en=%b err=%b prog=%b exp %b/%b/0", tag, bus0.en, bus0.err, bus0.prog, exp_en, exp_err); end
        tests++; if (bus0.word_cnt !== exp_cnt || bus0.addr !== exp_addr || bus0.instr !== exp_instr) begin
            failed++; $display("FAIL ignore_%s_regs got cnt=%0d addr=%h instr=%h exp %0d/%h/%h",
                               tag, bus0.word_cnt, bus0.addr, bus0.instr, exp_cnt, exp_addr, exp_instr); end
    endtask

    task automatic test_gapped_load();
        logic [7:0] bs [$] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                               8'hB7, 8'hF2, 8'hFF, 8'hFF};
        do_reset();
        foreach (bs[i]) begin
            send_byte(0, bs[i]);
            bus0.s_valid = 1'b0;
            tick(1);
            if (i == 9) tick(10);
        end
        tick(2);
        tests++; if (wlog_addr.size() != 2) begin failed++; $display("FAIL gap_write_count got %0d exp 2", wlog_addr.size()); end
        else begin
            tests++; if (wlog_addr[0] !== 32'h0 || wlog_instr[0] !== 32'h0010_0513) begin
                failed++; $display("FAIL gap_write0 got %h/%h exp 00000000/00100513", wlog_addr[0], wlog_instr[0]); end
            tests++; if (wlog_addr[1] !== 32'h4 || wlog_instr[1] !== 32'hFFFF_F2B7) begin
                failed++; $display("FAIL gap_write1 got %h/%h exp 00000004/fffff2b7", wlog_addr[1], wlog_instr[1]); end
        end
        tests++; if (bus0.done !== 1'b1 || bus0.word_cnt !== 16'd2) begin
            failed++; $display("FAIL gap_done got done=%b cnt=%0d exp 1/2", bus0.done, bus0.word_cnt); end
    endtask

    task automatic test_bad_len(input string tag, input logic [7:0] bs [$]);
        do_reset();
        send_bytes(0, bs);
        tick(2);
        tests++; if (bus0.err !== 1'b1 || bus0.busy !== 1'b0 || bus0.en !== 1'b0 || bus0.s_ready !== 1'b0) begin
            failed++; $display("FAIL %s_err got err=%b busy=%b en=%b s_ready=%b exp 1/0/0/0",
                               tag, bus0.err, bus0.busy, bus0.en, bus0.s_ready); end
        tests++; if (prog_seen0 !== 1'b0) begin failed++; $display("FAIL %s_prog got prog seen exp never", tag); end
    endtask

    task automatic test_max_len();
        do_reset();
        send_bytes(0, '{8'h00, 8'h04, 8'h00, 8'h00});
        tick(1);
        tests++; if (bus0.s_ready !== 1'b1 || bus0.err !== 1'b0 || bus0.busy !== 1'b1) begin
            failed++; $display("FAIL maxlen_accept got s_ready=%b err=%b busy=%b exp 1/0/1", bus0.s_ready, bus0.err, bus0.busy); end
    endtask

    task automatic test_wrap();
        do_reset();
        send_bytes(1, '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                        8'hF0, 8'hDE, 8'hBC, 8'h9A});
        tick(1);
        tests++; if (bus1.done !== 1'b1 || bus1.err !== 1'b0) begin
            failed++; $display("FAIL wrap_done got done=%b err=%b exp 1/0", bus1.done, bus1.err); end
        tests++; if (rd1(32'hFFFF_FFFC) !== 32'h1234_5678 || rd1(32'h0) !== 32'h9ABC_DEF0) begin
            failed++; $display("FAIL wrap_mem got [fffffffc]=%h [0]=%h exp 12345678/9abcdef0", rd1(32'hFFFF_FFFC), rd1(32'h0)); end
        tests++; if (bus1.addr !== 32'h0) begin failed++; $display("FAIL wrap_addr got %h exp 0", bus1.addr); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        send_bytes(0, '{8'h03, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                        8'h88, 8'h77, 8'h66, 8'h55, 8'hAA, 8'hBB});
        tests++; if (bus0.word_cnt !== 16'd2 || bus0.prog !== 1'b1) begin
            failed++; $display("FAIL mid_pre got cnt=%0d prog=%b exp 2/1", bus0.word_cnt, bus0.prog); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tests++; if (bus0.prog !== 1'b0 || bus0.word_cnt !== 16'd0 || bus0.addr !== 32'h0 || bus0.busy !== 1'b1) begin
            failed++; $display("FAIL mid_after_rst got prog=%b cnt=%0d addr=%h busy=%b exp 0/0/0/1",
                               bus0.prog, bus0.word_cnt, bus0.addr, bus0.busy); end
        clear_logs();
        send_bytes(0, '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        tick(1);
        tests++; if (rd0(32'h0) !== 32'hDEAD_BEEF || bus0.word_cnt !== 16'd1 || bus0.done !== 1'b1) begin
            failed++; $display("FAIL mid_reload got mem=%h cnt=%0d done=%b exp deadbeef/1/1", rd0(32'h0), bus0.word_cnt, bus0.done); end
    endtask

    initial begin
        bus0.s_data = 8'h00; bus0.s_valid = 1'b0;
        bus1.s_data = 8'h00; bus1.s_valid = 1'b0;
        test_reset();
        test_basic_load();
        test_ignore("run", 1'b1, 1'b0, 16'd2, 32'h4, 32'hFFFF_F2B7);
        test_gapped_load();
        test_bad_len("len0", '{8'h00, 8'h00, 8'h00, 8'h00});
        test_ignore("err", 1'b0, 1'b1, 16'd0, 32'h0, 32'h0);
        test_bad_len("len1025", '{8'h01, 8'h04, 8'h00, 8'h00});
        test_max_len();
        test_wrap();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
